atmr_sweep_ctrl: RTL and testbench

//  Exhaustive-sweep controller for an ATMR netlist (three replicas ori/mai/men + bitwise voter).
//  On start, drives every input vector once, then checks each replica's output word against the

---
 rtl/atmr_ctrl_pkg.sv | 22 ++
 rtl/atmr_div_cnt.sv | 36 +++
 rtl/atmr_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_atmr_sweep_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atmr_ctrl_pkg.sv
// Shared definitions for the ATMR exhaustive-sweep controller: FSM states,
// default widths and the bitwise majority helper used by the voter check.
package atmr_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int N_IN_DEF    = 7;
   localparam int N_OUT_DEF   = 10;
   localparam int DUT_LAT_DEF = 1;
   localparam int CNT_W_DEF   = 8;

   // Applied per bit position to build the majority of three output words.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/atmr_div_cnt.sv
// Divergence counter: saturating count of flagged vectors plus a latch of the
// first vector that was flagged since the last clear.
module atmr_div_cnt #(
   parameter int N_IN  = 7,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_mis,
   input  logic [N_IN-1:0]  i_vec,
   output logic [CNT_W-1:0] o_cnt,
   output logic [N_IN-1:0]  o_first
);

   logic [CNT_W-1:0] r_cnt;
   logic [N_IN-1:0]  r_first;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt   <= '0;
         r_first <= '0;
      end else if (i_en && i_mis) begin
         // A zero count means no mismatch yet, so this vector is the first one.
         if (r_cnt == '0)
            r_first <= i_vec;
         if (r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt   = r_cnt;
   assign o_first = r_first;

endmodule

// File: rtl/atmr_sweep_ctrl.sv
// Exhaustive-sweep controller for an ATMR block: walks every input vector once
// and counts replica divergences and voter faults on the latency-aligned outputs.
module atmr_sweep_ctrl
   import atmr_ctrl_pkg::*;
#(
   parameter int N_IN    = N_IN_DEF,
   parameter int N_OUT   = N_OUT_DEF,
   parameter int DUT_LAT = DUT_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   output logic [N_IN-1:0]  vec_o,
   output logic             vec_vld_o,
   input  logic [N_OUT-1:0] ori_i,
   input  logic [N_OUT-1:0] mai_i,
   input  logic [N_OUT-1:0] men_i,
   input  logic [N_OUT-1:0] vote_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] err_ori_o,
   output logic [CNT_W-1:0] err_mai_o,
   output logic [CNT_W-1:0] err_men_o,
   output logic [CNT_W-1:0] vfault_o,
   output logic [N_IN-1:0]  first_ori_o,
   output logic [N_IN-1:0]  first_mai_o,
   output logic [N_IN-1:0]  first_men_o
);

   localparam int              DW         = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
   localparam logic [DW-1:0]   DRAIN_LAST = DW'(DUT_LAT - 1);
   localparam logic [N_IN-1:0] LAST_VEC   = '1;

   state_e            r_state;
   logic [N_IN-1:0]   r_vec;
   logic              r_vld;
   logic [DW-1:0]     r_drain;
   logic              w_go;
   logic              w_clr;
   logic              w_en;
   logic              w_tap_vld;
   logic [N_IN-1:0]   w_tap_vec;
   logic [N_OUT-1:0]  w_maj;
   logic [N_IN-1:0]   w_vf_first_unused;

   // Abort outranks start whenever both arrive together.
   assign w_go  = start_i & ~abort_i;
   assign w_clr = w_go & ((r_state == ST_IDLE) | (r_state == ST_DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_vld   <= 1'b0;
         r_drain <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_go) begin
                  r_state <= ST_SWEEP;
                  r_vec   <= '0;
                  r_vld   <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SWEEP: begin
               if (abort_i) begin
                  r_state <= ST_IDLE;
                  r_vld   <= 1'b0;
               end else if (r_vec == LAST_VEC) begin
                  r_state <= ST_DRAIN;
                  r_vld   <= 1'b0;
                  r_drain <= '0;
               end else begin
                  r_vec <= r_vec + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (abort_i)
                  r_state <= ST_IDLE;
               else if (r_drain == DRAIN_LAST)
                  r_state <= ST_DONE;
               else
                  r_drain <= r_drain + 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign vec_o     = r_vec;
   assign vec_vld_o = r_vld;
   assign busy_o    = (r_state == ST_SWEEP) | (r_state == ST_DRAIN);
   assign done_o    = (r_state == ST_DONE);

   // Latency alignment: the registered vector itself is the first tap stage.
   generate
      if (DUT_LAT == 1) begin : g_lat1
         assign w_tap_vld = r_vld;
         assign w_tap_vec = r_vec;
      end else begin : g_latn
         logic            r_vld_p [DUT_LAT-1];
         logic [N_IN-1:0] r_vec_p [DUT_LAT-1];

         always_ff @(posedge clk) begin
            if (rst || abort_i) begin
               for (int i = 0; i < DUT_LAT - 1; i++)
                  r_vld_p[i] <= 1'b0;
            end else begin
               r_vld_p[0] <= r_vld;
               for (int i = 1; i < DUT_LAT - 1; i++)
                  r_vld_p[i] <= r_vld_p[i-1];
            end
         end

         always_ff @(posedge clk) begin
            r_vec_p[0] <= r_vec;
            for (int i = 1; i < DUT_LAT - 1; i++)
               r_vec_p[i] <= r_vec_p[i-1];
         end

         assign w_tap_vld = r_vld_p[DUT_LAT-2];
         assign w_tap_vec = r_vec_p[DUT_LAT-2];
      end
   endgenerate

   assign w_en = w_tap_vld & ~abort_i;

   always_comb begin
      w_maj = '0;
      for (int b = 0; b < N_OUT; b++)
         w_maj[b] = maj3(ori_i[b], mai_i[b], men_i[b]);
   end

   atmr_div_cnt #(.N_IN(N_IN), .CNT_W(CNT_W)) u_cnt_ori (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_en), .i_mis(ori_i != vote_i),
      .i_vec(w_tap_vec), .o_cnt(err_ori_o), .o_first(first_ori_o));

   atmr_div_cnt #(.N_IN(N_IN), .CNT_W(CNT_W)) u_cnt_mai (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_en), .i_mis(mai_i != vote_i),
      .i_vec(w_tap_vec), .o_cnt(err_mai_o), .o_first(first_mai_o));

   atmr_div_cnt #(.N_IN(N_IN), .CNT_W(CNT_W)) u_cnt_men (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_en), .i_mis(men_i != vote_i),
      .i_vec(w_tap_vec), .o_cnt(err_men_o), .o_first(first_men_o));

   atmr_div_cnt #(.N_IN(N_IN), .CNT_W(CNT_W)) u_cnt_vf (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_en), .i_mis(vote_i != w_maj),
      .i_vec(w_tap_vec), .o_cnt(vfault_o), .o_first(w_vf_first_unused));

endmodule

// File: tb/tb_atmr_sweep_ctrl.sv
// Bench for atmr_sweep_ctrl: table-driven ATMR replica model, directed sweeps,
// randomized replica faults and an arithmetic reference for the expected counts.
module tb_atmr_sweep_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [9:0] t_base [128];
   logic [9:0] t_eo   [128];
   logic [9:0] t_ea   [128];
   logic [9:0] t_em   [128];
   logic [9:0] t_vf   [128];

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [9:0] bmaj(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Instance A: default parameters, combinational ATMR model.
   logic       start_a, abort_a, vld_a, busy_a, done_a;
   logic [6:0] vec_a, fo_a, fa_a, fm_a;
   logic [9:0] ori_a, mai_a, men_a, vote_a;
   logic [7:0] eo_a, ea_a, em_a, vf_a;

   always_comb begin
      ori_a  = t_base[vec_a] ^ t_eo[vec_a];
      mai_a  = t_base[vec_a] ^ t_ea[vec_a];
      men_a  = t_base[vec_a] ^ t_em[vec_a];
      vote_a = bmaj(ori_a, mai_a, men_a) ^ t_vf[vec_a];
   end

   atmr_sweep_ctrl u_a (
      .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a),
      .vec_o(vec_a), .vec_vld_o(vld_a),
      .ori_i(ori_a), .mai_i(mai_a), .men_i(men_a), .vote_i(vote_a),
      .busy_o(busy_a), .done_o(done_a),
      .err_ori_o(eo_a), .err_mai_o(ea_a), .err_men_o(em_a), .vfault_o(vf_a),
      .first_ori_o(fo_a), .first_mai_o(fa_a), .first_men_o(fm_a));

   // Instance B: DUT_LAT=3 (two pipeline registers in the ATMR model), CNT_W=4.
   logic       start_b, abort_b, vld_b, busy_b, done_b;
   logic [6:0] vec_b, fo_b, fa_b, fm_b, b_d1, b_d2;
   logic [9:0] ori_b, mai_b, men_b, vote_b;
   logic [3:0] eo_b, ea_b, em_b, vf_b;

   always @(posedge clk) begin
      b_d1 <= vec_b;
      b_d2 <= b_d1;
   end

   always_comb begin
      ori_b  = t_base[b_d2] ^ t_eo[b_d2];
      mai_b  = t_base[b_d2] ^ t_ea[b_d2];
      men_b  = t_base[b_d2] ^ t_em[b_d2];
      vote_b = bmaj(ori_b, mai_b, men_b) ^ t_vf[b_d2];
   end

   atmr_sweep_ctrl #(.N_IN(7), .N_OUT(10), .DUT_LAT(3), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b),
      .vec_o(vec_b), .vec_vld_o(vld_b),
      .ori_i(ori_b), .mai_i(mai_b), .men_i(men_b), .vote_i(vote_b),
      .busy_o(busy_b), .done_o(done_b),
      .err_ori_o(eo_b), .err_mai_o(ea_b), .err_men_o(em_b), .vfault_o(vf_b),
      .first_ori_o(fo_b), .first_mai_o(fa_b), .first_men_o(fm_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: walk vectors 0..nv-1 and count divergences from the spec rules.
   task automatic model(input int nv, input int cmax,
                        output int e_o, output int e_a, output int e_m, output int e_v,
                        output int f_o, output int f_a, output int f_m);
      int co, ca, cm, cv;
      logic [9:0] o, a, m, vt;
      co = 0; ca = 0; cm = 0; cv = 0; f_o = 0; f_a = 0; f_m = 0;
      for (int v = 0; v < nv; v++) begin
         o  = t_base[v] ^ t_eo[v];
         a  = t_base[v] ^ t_ea[v];
         m  = t_base[v] ^ t_em[v];
         vt = bmaj(o, a, m) ^ t_vf[v];
         if (o != vt) begin if (co == 0) f_o = v; co++; end
         if (a != vt) begin if (ca == 0) f_a = v; ca++; end
         if (m != vt) begin if (cm == 0) f_m = v; cm++; end
         if (vt != bmaj(o, a, m)) cv++;
      end
      e_o = (co > cmax) ? cmax : co;
      e_a = (ca > cmax) ? cmax : ca;
      e_m = (cm > cmax) ? cmax : cm;
      e_v = (cv > cmax) ? cmax : cv;
   endtask

   task automatic check_a(input string tag, input int nv);
      int e_o, e_a, e_m, e_v, f_o, f_a, f_m;
      model(nv, 255, e_o, e_a, e_m, e_v, f_o, f_a, f_m);
      chk({tag, "_err_ori"}, 32'(eo_a), 32'(e_o));
      chk({tag, "_err_mai"}, 32'(ea_a), 32'(e_a));
      chk({tag, "_err_men"}, 32'(em_a), 32'(e_m));
      chk({tag, "_vfault"},  32'(vf_a), 32'(e_v));
      chk({tag, "_first_ori"}, 32'(fo_a), 32'(f_o));
      chk({tag, "_first_mai"}, 32'(fa_a), 32'(f_a));
      chk({tag, "_first_men"}, 32'(fm_a), 32'(f_m));
   endtask

   task automatic check_b(input string tag);
      int e_o, e_a, e_m, e_v, f_o, f_a, f_m;
      model(128, 15, e_o, e_a, e_m, e_v, f_o, f_a, f_m);
      chk({tag, "_err_ori"}, 32'(eo_b), 32'(e_o));
      chk({tag, "_err_mai"}, 32'(ea_b), 32'(e_a));
      chk({tag, "_err_men"}, 32'(em_b), 32'(e_m));
      chk({tag, "_vfault"},  32'(vf_b), 32'(e_v));
      chk({tag, "_first_ori"}, 32'(fo_b), 32'(f_o));
      chk({tag, "_first_mai"}, 32'(fa_b), 32'(f_a));
      chk({tag, "_first_men"}, 32'(fm_b), 32'(f_m));
   endtask

   task automatic fill_clean();
      for (int v = 0; v < 128; v++) begin
         t_base[v] = 10'($urandom);
         t_eo[v] = '0; t_ea[v] = '0; t_em[v] = '0; t_vf[v] = '0;
      end
   endtask

   task automatic fill_random(input int p_rep, input int p_vf);
      for (int v = 0; v < 128; v++) begin
         t_base[v] = 10'($urandom);
         t_eo[v] = ($urandom_range(p_rep - 1, 0) == 0) ? 10'($urandom_range(1023, 1)) : 10'd0;
         t_ea[v] = ($urandom_range(p_rep - 1, 0) == 0) ? 10'($urandom_range(1023, 1)) : 10'd0;
         t_em[v] = ($urandom_range(p_rep - 1, 0) == 0) ? 10'($urandom_range(1023, 1)) : 10'd0;
         t_vf[v] = ($urandom_range(p_vf - 1, 0) == 0) ? 10'($urandom_range(1023, 1)) : 10'd0;
      end
   endtask

   task automatic pulse_start_a();
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic sweep_a(input string tag);
      int seen;
      seen = 0;
      pulse_start_a();
      for (int c = 1; c <= 200 && seen == 0; c++) begin
         @(negedge clk);
         if (done_a) seen = c;
      end
      chk({tag, "_done_cycle"}, 32'(seen), 32'd130);
      @(negedge clk);
      check_a(tag, 128);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount, d1, d2;
      rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      fill_clean();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_vec_a", 32'(vec_a), 0);
      chk("rst_vld_a", 32'(vld_a), 0);
      chk("rst_busy_a", 32'(busy_a), 0);
      chk("rst_done_a", 32'(done_a), 0);
      check_a("rst_a", 0);
      chk("rst_busy_b", 32'(busy_b), 0);
      chk("rst_cnt_b", 32'({eo_b, ea_b, em_b, vf_b}), 0);

      // T1: clean replicas, cycle-accurate timing; a start mid-sweep is ignored.
      fill_clean();
      pulse_start_a();
      for (int c = 1; c <= 131; c++) begin
         @(negedge clk);
         chk($sformatf("t1_busy_c%0d", c), 32'(busy_a), 32'(c <= 129));
         chk($sformatf("t1_done_c%0d", c), 32'(done_a), 32'(c == 130));
         chk($sformatf("t1_vld_c%0d", c),  32'(vld_a),  32'(c <= 128));
         chk($sformatf("t1_vec_c%0d", c),  32'(vec_a),  32'((c <= 128) ? c - 1 : 127));
         start_a = (c == 50);
      end
      start_a = 1'b0;
      check_a("t1", 128);

      // T2: mai bit0 stuck at 1 on even vectors.
      fill_clean();
      for (int v = 0; v < 128; v++) begin
         t_base[v] = t_base[v] & 10'h3FE;
         t_ea[v]   = (v % 2 == 0) ? 10'd1 : 10'd0;
      end
      sweep_a("t2");
      chk("t2_err_mai_const", 32'(ea_a), 64);
      chk("t2_first_mai_const", 32'(fa_a), 0);

      // T3: vote forced to all-ones on vector 5 only.
      fill_clean();
      for (int v = 0; v < 128; v++) t_base[v] = t_base[v] & 10'h1FF;
      t_vf[5] = t_base[5] ^ 10'h3FF;
      sweep_a("t3");
      chk("t3_vfault_const", 32'(vf_a), 1);
      chk("t3_err_ori_const", 32'(eo_a), 1);

      // Randomized replica and voter faults.
      for (int r = 0; r < 3; r++) begin
         fill_random(8, 16);
         sweep_a($sformatf("rnd%0d", r));
      end

      // T5: abort at cycle 40, counters hold; then rst mid-sweep zeroes everything.
      fill_random(6, 12);
      dcount = 0;
      pulse_start_a();
      for (int c = 1; c <= 160; c++) begin
         @(negedge clk);
         if (done_a) dcount++;
         if (c == 41) begin
            chk("t5_busy_41", 32'(busy_a), 0);
            chk("t5_vld_41", 32'(vld_a), 0);
            chk("t5_vec_41", 32'(vec_a), 39);
         end
         abort_a = (c == 40);
      end
      abort_a = 1'b0;
      chk("t5_no_done", 32'(dcount), 0);
      check_a("t5_abort", 39);
      @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
      @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
      @(negedge clk);
      chk("t5_abort_wins", 32'(busy_a), 0);
      check_a("t5_hold", 39);
      pulse_start_a();
      for (int c = 1; c <= 61; c++) begin
         @(negedge clk);
         rst = (c == 60);
      end
      rst = 1'b0;
      chk("t5_rst_busy", 32'(busy_a), 0);
      chk("t5_rst_vec", 32'(vec_a), 0);
      chk("t5_rst_vld", 32'(vld_a), 0);
      check_a("t5_rst", 0);

      // T4 + T6: instance B, ori always wrong, start held -> back-to-back sweeps.
      fill_clean();
      for (int v = 0; v < 128; v++) t_eo[v] = 10'($urandom_range(1023, 1));
      dcount = 0; d1 = 0; d2 = 0;
      @(negedge clk); start_b = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 270; c++) begin
         @(negedge clk);
         if (done_b) begin
            dcount++;
            if (dcount == 1) d1 = c; else if (dcount == 2) d2 = c;
         end
         if (c == 1)   chk("t6_vec_c1", 32'({vld_b, vec_b}), 32'h80);
         if (c == 131) chk("t6_busy_131", 32'(busy_b), 1);
         if (c == 132) chk("t6_busy_132", 32'(busy_b), 0);
         if (c == 133) chk("t6_busy_133", 32'(busy_b), 1);
         if (c == 264) start_b = 1'b0;
      end
      chk("t6_done_count", 32'(dcount), 2);
      chk("t6_done1", 32'(d1), 132);
      chk("t6_done2", 32'(d2), 264);
      check_b("t4");
      chk("t4_sat_const", 32'(eo_b), 15);

      // Instance B with sparse random faults to exercise latency alignment.
      fill_random(16, 24);
      @(negedge clk); start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      d1 = 0;
      for (int c = 1; c <= 200 && d1 == 0; c++) begin
         @(negedge clk);
         if (done_b) d1 = c;
      end
      chk("b_rnd_done", 32'(d1), 132);
      @(negedge clk);
      check_b("b_rnd");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
